// File: rtl/rom_dl_sequencer_if.sv
// Bus bundle for rom_dl_sequencer: data_io ioctl download stream, the two
// SDRAM write ports (toggle req/ack) and the core status outputs.
// Optional macro ROM_CHKSUM_EN adds the rom_chksum signal.
interface rom_dl_sequencer_if;
    logic        ioctl_downl;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    logic        port1_req;
    logic        port1_ack;
    logic [22:0] port1_a;
    logic [1:0]  port1_ds;
    logic [15:0] port1_d;

    logic        port2_req;
    logic        port2_ack;
    logic [22:0] port2_a;
    logic [1:0]  port2_ds;
    logic [15:0] port2_d;

    logic        port_we;
    logic        rom_loaded;
    logic        core_reset;
    logic        overflow;
`ifdef ROM_CHKSUM_EN
    logic [15:0] rom_chksum;
`endif

    // Sequencer side.
    modport master (
        input  ioctl_downl, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout,
        input  port1_ack, port2_ack,
        output port1_req, port1_a, port1_ds, port1_d,
        output port2_req, port2_a, port2_ds, port2_d,
        output port_we, rom_loaded, core_reset, overflow
`ifdef ROM_CHKSUM_EN
        , output rom_chksum
`endif
    );

    // Environment side (data_io + sdram + core).
    modport slave (
        output ioctl_downl, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout,
        output port1_ack, port2_ack,
        input  port1_req, port1_a, port1_ds, port1_d,
        input  port2_req, port2_a, port2_ds, port2_d,
        input  port_we, rom_loaded, core_reset, overflow
`ifdef ROM_CHKSUM_EN
        , input rom_chksum
`endif
    );
endinterface

// File: rtl/rom_dl_sequencer.sv
// rom_dl_sequencer: buffers ROM download bytes in a small FIFO and writes them
// into SDRAM port1 (CPU ROM) or port2 (GFX ROM, rebased) with toggle req/ack
// handshakes; generates rom_loaded / core_reset. Runs on clk_sys (= clk_sd).
// Optional macro ROM_CHKSUM_EN: 16-bit byte sum of accepted ROM bytes.
module rom_dl_sequencer #(
    parameter logic [7:0]  ROM_INDEX  = 8'h00,
    parameter logic [24:0] GFX_BASE   = 25'h10000,
    parameter logic [24:0] ROM_END    = 25'h20000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic                clk_sys,
    input logic                reset_n,
    rom_dl_sequencer_if.master bus
);
    localparam int unsigned  PW       = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]  CNT_FULL = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          sel_gfx_q;

    logic          wr_q;
    logic          downl_q;
    logic          acc_q;
    logic [24:0]   acc_addr;
    logic [7:0]    acc_data;
    logic          rom_pend;

    logic [32:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;

    logic          is_rom, accept, rom_start;
    logic          fifo_empty, fifo_full;
    logic          push, pop, drop;

    logic [32:0]   head;
    logic [24:0]   h_addr, h_off;
    logic [7:0]    h_data;
    logic          h_gfx;
    logic [22:0]   h_word;
    logic [1:0]    h_ds;

    assign is_rom     = (bus.ioctl_index == ROM_INDEX);
    assign accept     = bus.ioctl_wr & ~wr_q & bus.ioctl_downl & is_rom & (bus.ioctl_addr < ROM_END);
    assign rom_start  = bus.ioctl_downl & ~downl_q & is_rom;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_FULL);
    // A full FIFO still takes the byte when the head is popped in the same cycle.
    assign push       = acc_q & (~fifo_full | pop);
    assign drop       = acc_q & fifo_full & ~pop;

    // Register the strobe edge and capture the qualified byte; pushed next cycle.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            wr_q     <= 1'b0;
            acc_q    <= 1'b0;
            acc_addr <= '0;
            acc_data <= '0;
        end else begin
            wr_q  <= bus.ioctl_wr;
            acc_q <= accept;
            if (accept) begin
                acc_addr <= bus.ioctl_addr;
                acc_data <= bus.ioctl_dout;
            end
        end
    end

    // FIFO storage (no reset needed; guarded by count).
    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {acc_addr, acc_data};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Decode FIFO head into port routing and word address.
    always_comb begin
        head   = fifo_mem[rd_ptr];
        h_addr = head[32:8];
        h_data = head[7:0];
        h_gfx  = (h_addr >= GFX_BASE);
        h_off  = h_gfx ? (h_addr - GFX_BASE) : h_addr;
        h_word = 23'(h_off >> 1);
        h_ds   = {h_addr[0], ~h_addr[0]};
    end

    // FSM state register.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // FSM next state: pop in IDLE, wait for the selected port's ack in WAIT.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sel_gfx_q ? (bus.port2_ack == bus.port2_req)
                              : (bus.port1_ack == bus.port1_req)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Port outputs: load the selected port and toggle its request on pop.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            bus.port1_req <= bus.port1_ack;
            bus.port1_a   <= '0;
            bus.port1_ds  <= '0;
            bus.port1_d   <= '0;
            bus.port2_req <= bus.port2_ack;
            bus.port2_a   <= '0;
            bus.port2_ds  <= '0;
            bus.port2_d   <= '0;
            sel_gfx_q     <= 1'b0;
        end else if (pop) begin
            sel_gfx_q <= h_gfx;
            if (h_gfx) begin
                bus.port2_a   <= h_word;
                bus.port2_ds  <= h_ds;
                bus.port2_d   <= {h_data, h_data};
                bus.port2_req <= ~bus.port2_req;
            end else begin
                bus.port1_a   <= h_word;
                bus.port1_ds  <= h_ds;
                bus.port1_d   <= {h_data, h_data};
                bus.port1_req <= ~bus.port1_req;
            end
        end
    end

    // Download status: rom_loaded waits for the buffered bytes to drain.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            downl_q        <= 1'b0;
            rom_pend       <= 1'b0;
            bus.rom_loaded <= 1'b0;
            bus.core_reset <= 1'b1;
            bus.port_we    <= 1'b0;
            bus.overflow   <= 1'b0;
        end else begin
            downl_q        <= bus.ioctl_downl;
            bus.port_we    <= bus.ioctl_downl;
            bus.core_reset <= ~bus.rom_loaded | (bus.ioctl_downl & is_rom);
            if (drop) bus.overflow <= 1'b1;
            if (rom_start) begin
                bus.rom_loaded <= 1'b0;
                rom_pend       <= 1'b1;
            end else if (rom_pend & ~bus.ioctl_downl & ~acc_q & fifo_empty & (state_q == S_IDLE)) begin
                bus.rom_loaded <= 1'b1;
                rom_pend       <= 1'b0;
            end
        end
    end

`ifdef ROM_CHKSUM_EN
    // Running byte sum of every byte that actually entered the FIFO.
    always_ff @(posedge clk_sys) begin
        if (!reset_n || rom_start) bus.rom_chksum <= '0;
        else if (push)             bus.rom_chksum <= bus.rom_chksum + {8'h00, acc_data};
    end
`endif
endmodule
